// File: rtl/bure_core_pkg.sv
// Shared BureCore definitions: reset PC default, fetch credit limit and
// the fetch-entry record carried between fetch and decode.
package bure_core_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT     = 32'h0000_0000;
  localparam int unsigned IMEM_MAX_OUTSTANDING = 2;
  localparam int unsigned XLEN                 = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // True when one more fetch still fits in the response buffer even if
  // every in-flight fetch and every buffered entry is still pending.
  function automatic logic credit_ok(input logic [1:0] outstanding,
                                     input logic [1:0] fifo_count);
    logic [2:0] total;
    total = {1'b0, outstanding} + {1'b0, fifo_count};
    return (total < 3'(IMEM_MAX_OUTSTANDING));
  endfunction

endpackage

// File: rtl/bure_if_interface.sv
// Fetch-to-decode bundle: one-cycle instruction pulse with its PC.
interface bure_if_interface #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0]  pc;

  modport master (output instr_valid, output instr, output pc);
  modport slave  (input  instr_valid, input  instr, input  pc);
endinterface

// File: rtl/bure_fifo2.sv
// Two-entry synchronous FIFO with flush; head entry is always on data_o.
module bure_fifo2 #(
  parameter int unsigned W = 64
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop_s;

  assign pop_s   = pop_i && (count_q != 2'd0);
  assign data_o  = head_q;
  assign count_o = count_q;

  // Next-state: flush wins, then push/pop combinations; a push into a full
  // FIFO is dropped (callers never do this).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d  = data_i;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            tail_d  = data_i;
            count_d = 2'd2;
          end else begin
            count_d = count_q;
          end
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = data_i;
          end else begin
            head_d = tail_q;
            tail_d = data_i;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bure_stage_if.sv
// BureCore instruction-fetch stage: PC, credit-limited memory requests,
// response tagging, kill of stale responses on redirect, and a registered
// one-cycle instruction pulse to decode.
module bure_stage_if
  import bure_core_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_stall,
  input  logic                   i_redirect,
  input  logic [DATA_WIDTH-1:0]  i_redirect_pc,
  output logic                   o_imem_req,
  output logic [DATA_WIDTH-1:0]  o_imem_addr,
  input  logic                   i_imem_gnt,
  input  logic                   i_imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  bure_if_interface.master       if_if
);

  localparam int unsigned EW = DATA_WIDTH + INSTR_WIDTH;

  logic                   run_q;
  logic [DATA_WIDTH-1:0]  pc_q, pc_d;
  logic [1:0]             outst_q, outst_d;
  logic [1:0]             kill_q, kill_d;
  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0]  opc_q, opc_d;

  logic                   req_s, grant_s, rvalid_ok_s, resp_live_s;
  logic                   rsp_push_s, rsp_pop_s;
  logic [1:0]             rsp_count_s, tag_count_s;
  logic [EW-1:0]          rsp_head_s;
  logic [DATA_WIDTH-1:0]  tag_pc_s;

  // A response is only counted if something is in flight; a response is
  // delivered only when it is not being killed and its tag is present.
  assign req_s       = run_q && !i_redirect && credit_ok(outst_q, rsp_count_s);
  assign grant_s     = req_s && i_imem_gnt;
  assign rvalid_ok_s = i_imem_rvalid && (outst_q != 2'd0);
  assign resp_live_s = rvalid_ok_s && (kill_q == 2'd0) && !i_redirect &&
                       (tag_count_s != 2'd0);

  assign o_imem_req  = req_s;
  assign o_imem_addr = pc_q;

  assign if_if.instr_valid = valid_q;
  assign if_if.instr       = instr_q;
  assign if_if.pc          = opc_q;

  bure_fifo2 #(.W(DATA_WIDTH)) u_tag_fifo (
    .clk_i   (i_clk),
    .rstn_i  (i_rstn),
    .flush_i (i_redirect),
    .push_i  (grant_s),
    .data_i  (pc_q),
    .pop_i   (resp_live_s),
    .data_o  (tag_pc_s),
    .count_o (tag_count_s)
  );

  bure_fifo2 #(.W(EW)) u_rsp_fifo (
    .clk_i   (i_clk),
    .rstn_i  (i_rstn),
    .flush_i (i_redirect),
    .push_i  (rsp_push_s),
    .data_i  ({tag_pc_s, i_imem_rdata}),
    .pop_i   (rsp_pop_s),
    .data_o  (rsp_head_s),
    .count_o (rsp_count_s)
  );

  // PC, in-flight count and kill count; redirect reloads PC and marks every
  // still-pending response as stale.
  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q;
    kill_d  = kill_q;
    if (grant_s) begin
      pc_d = pc_q + DATA_WIDTH'(4);
    end else begin
      pc_d = pc_q;
    end
    if (grant_s && !rvalid_ok_s) begin
      outst_d = outst_q + 2'd1;
    end else if (!grant_s && rvalid_ok_s) begin
      outst_d = outst_q - 2'd1;
    end else begin
      outst_d = outst_q;
    end
    if (i_redirect) begin
      pc_d   = i_redirect_pc & ~DATA_WIDTH'(3);
      kill_d = outst_d;
    end else if (rvalid_ok_s && (kill_q != 2'd0)) begin
      kill_d = kill_q - 2'd1;
    end else begin
      kill_d = kill_q;
    end
  end

  // Output slot: oldest buffered entry first, else bypass the live response;
  // stall or redirect suppress the pulse.
  always_comb begin
    rsp_push_s = 1'b0;
    rsp_pop_s  = 1'b0;
    valid_d    = 1'b0;
    instr_d    = instr_q;
    opc_d      = opc_q;
    if (i_redirect) begin
      valid_d = 1'b0;
    end else if (i_stall) begin
      rsp_push_s = resp_live_s;
    end else if (rsp_count_s != 2'd0) begin
      rsp_pop_s        = 1'b1;
      rsp_push_s       = resp_live_s;
      valid_d          = 1'b1;
      {opc_d, instr_d} = rsp_head_s;
    end else if (resp_live_s) begin
      valid_d = 1'b1;
      opc_d   = tag_pc_s;
      instr_d = i_imem_rdata;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Stage state registers.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      run_q   <= 1'b0;
      pc_q    <= RESET_PC;
      outst_q <= 2'd0;
      kill_q  <= 2'd0;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
    end else begin
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      kill_q  <= kill_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
    end
  end

endmodule

// File: doc/bure_stage_if.md
# bure_stage_if

Instruction-fetch stage of BureCore: owns the program counter, issues word requests to instruction memory, buffers returned instructions and presents them to the decode stage through `bure_if_interface`. Accepts control-flow redirects from later stages, discards in-flight fetches on redirect, and holds instructions while the pipeline is stalled.

## Interface
Parameters:
- DATA_WIDTH, 32, PC / address width
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC after reset (bits [1:0] must be 0)

Ports:
- i_clk  input  1  clock; one clock domain, all state on rising edge
- i_rstn  input  1  reset; synchronous and active-low
- i_stall  input  1  hazard hold from pipeline control
- i_redirect  input  1  branch/jump taken, flush and refetch
- i_redirect_pc  input  DATA_WIDTH  new PC; bits [1:0] ignored (forced 0)
- o_imem_req  output  1  fetch request
- o_imem_addr  output  DATA_WIDTH  fetch address (= pc)
- i_imem_gnt  input  1  request accepted this cycle
- i_imem_rvalid  input  1  response valid (in request order, ≥1 cycle after grant)
- i_imem_rdata  input  INSTR_WIDTH  response instruction
- if_if  master  bure_if_interface  drives instr_valid (1), instr (INSTR_WIDTH), pc (DATA_WIDTH)

## Operation
- State: pc, outstanding count (0..2), kill count (0..2), 2-entry response FIFO of {pc, instr}, output register {instr_valid, instr, pc}, run flag.
- Reset (i_rstn low at edge): pc=RESET_PC, outstanding=0, kill=0, FIFO empty, run=0, instr_valid=0, instr=0, if_if.pc=0. o_imem_req=0 while run=0; run sets on first edge with i_rstn high.
- Request: o_imem_req = run && !i_redirect && (outstanding + fifo_count < 2). o_imem_addr = pc. On req && gnt: pc += 4 (wraps modulo 2^DATA_WIDTH), outstanding++.
- Response tag: fetch pc pushed into a 2-deep tag queue on grant, popped on rvalid; response carries that pc.
- Response: on rvalid, outstanding--. If kill>0: kill--, data dropped. Else: bypass to output register if FIFO empty and output slot free (not stalled); otherwise push to FIFO. Credit rule guarantees FIFO never overflows.
- Output: each non-stalled cycle output register loads FIFO head (pop) or bypass data, instr_valid=1; else instr_valid=0. instr_valid is a one-cycle pulse per instruction; decode has no backpressure.
- Stall: while i_stall=1, next instr_valid=0, no pop; pending instruction retained in FIFO and presented on first cycle after stall drops. Requests continue while credit allows.
- Redirect (priority over stall): pc=i_redirect_pc & ~3; FIFO and tag queue flushed; kill=outstanding minus any response arriving same cycle (that response dropped); next instr_valid=0; no request in redirect cycle.
- Simultaneous grant and rvalid: outstanding unchanged.
- Second redirect while kill>0: kill recomputed from current outstanding; no stale instruction ever reaches decode.

## Timing
- Zero-wait memory (rvalid cycle after gnt): request at t, instr_valid at t+2, sustained one instruction per cycle.
- Redirect at t: first request to new PC at t+1; earliest instr_valid for it at t+3.
- Stall release at t: buffered instruction valid at t+1.
- All if_if outputs registered; o_imem_req/o_imem_addr combinational from registers and i_redirect only.

## Structure
- Shared package bure_core_pkg: RESET_PC default, IMEM_MAX_OUTSTANDING=2, fetch-entry struct {pc, instr}.
- Sub-module bure_fifo2: 2-entry synchronous FIFO with push/pop/flush, count output; instantiated for response buffer (tag queue may reuse it).

## Test plan
- Reset then zero-wait memory returning addr as data: instr_valid pulses at consecutive cycles with pc 0x0,0x4,0x8; instr matches.
- Stall 3 cycles mid-stream: no instr_valid during stall, no instruction lost or duplicated, FIFO count ≤2, sequence resumes in order.
- Redirect to 0x103 with 2 outstanding: both responses dropped, next request addr 0x100, next delivered pc 0x100.
- Redirect coinciding with rvalid and stall: response dropped, instr_valid=0 next cycle, fetch resumes at redirect pc.
- Memory gnt withheld 5 cycles, rvalid delayed 3 cycles: req held with stable addr, pc advances only on grant, outstanding never exceeds 2.
- Assert i_rstn low mid-stream with 2 outstanding: all outputs return to reset values next edge, first request after release at RESET_PC.
